dvp_frame_tx: RTL



---
 rtl/dvp_pkg.sv | 44 ++++
 rtl/dvp_frame_tx_timing_gen.sv | 80 ++++++++
 rtl/dvp_frame_tx.sv | 102 ++++++++++
 3 files changed

// File: rtl/dvp_pkg.sv
// rtl/dvp_pkg.sv - DVP transmitter timing defaults, state encoding and RGB565 colour-bar palette
package dvp_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_BLANK  = 144;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 17;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBP    = 3'd2,
    ACTIVE = 3'd3,
    VFP    = 3'd4
  } dvp_state_e;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  // Left-to-right order of the classic 8-band colour bar.
  function automatic logic [15:0] bar_colour(input logic [2:0] band);
    logic [15:0] c;
    case (band)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_frame_tx_timing_gen.sv
// rtl/dvp_frame_tx_timing_gen.sv - byte/line counters and frame FSM; emits next-cycle DVP strobes
module dvp_timing_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        vsync_nx,
  output logic        href_nx,
  output logic        fetch_nx,
  output logic        frame_start_nx,
  output logic [15:0] pix_x
);

  localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_LINES = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int BW          = $clog2(LINE_LEN);
  localparam int LW          = $clog2(FRAME_LINES);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_VSYNC  = VSYNC;
  localparam logic [2:0] ST_VBP    = VBP;
  localparam logic [2:0] ST_ACTIVE = ACTIVE;
  localparam logic [2:0] ST_VFP    = VFP;

  logic [2:0]    state;
  logic [2:0]    state_eol;
  logic [BW-1:0] byte_cnt;
  logic [LW-1:0] line_cnt;
  logic          line_end;
  logic          frame_end;

  assign line_end  = (byte_cnt == BW'(LINE_LEN - 1));
  assign frame_end = (line_cnt == LW'(FRAME_LINES - 1));

  // State the FSM moves to when the current line finishes.
  always_comb begin
    state_eol = state;
    case (state)
      ST_VSYNC:  if (line_cnt == LW'(V_SYNC - 1)) state_eol = ST_VBP;
      ST_VBP:    if (line_cnt == LW'(V_SYNC + V_BP - 1)) state_eol = ST_ACTIVE;
      ST_ACTIVE: if (line_cnt == LW'(V_SYNC + V_BP + V_ACTIVE - 1)) state_eol = ST_VFP;
      ST_VFP:    if (frame_end) state_eol = enable ? ST_VSYNC : ST_IDLE;
      default:   state_eol = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      byte_cnt <= '0;
      line_cnt <= '0;
    end else if (state == ST_IDLE) begin
      byte_cnt <= '0;
      line_cnt <= '0;
      if (enable) state <= ST_VSYNC;
    end else if (line_end) begin
      byte_cnt <= '0;
      line_cnt <= frame_end ? '0 : line_cnt + 1'b1;
      state    <= state_eol;
    end else begin
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  // Counters describe the position the registered outputs will show next cycle.
  assign vsync_nx       = (state == ST_VSYNC);
  assign frame_start_nx = vsync_nx && (byte_cnt == '0) && (line_cnt == '0);
  assign href_nx        = (state == ST_ACTIVE) && (byte_cnt < BW'(2 * H_ACTIVE));
  assign fetch_nx       = href_nx && !byte_cnt[0];
  assign pix_x          = 16'(byte_cnt >> 1);

endmodule

// File: rtl/dvp_frame_tx.sv
// rtl/dvp_frame_tx.sv - RGB565 stream to DVP vsync/href/p_data transmitter; colour bars under DVP_TX_TEST_PATTERN_EN
module dvp_frame_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP
) (
  input  logic        p_clock,
  input  logic        rst_n,
  input  logic        enable,
`ifdef DVP_TX_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  input  logic [15:0] s_pixel,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  p_data,
  output logic        frame_start,
  output logic        underrun,
  input  logic        clr_underrun
);

  logic        vsync_nx;
  logic        href_nx;
  logic        fetch_nx;
  logic        frame_start_nx;
  logic [15:0] pix_x;
  logic        use_pattern;
  logic [15:0] bar_pixel;
  logic [15:0] pix_src;
  logic [15:0] pix_q;
  logic        underrun_set;

  dvp_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP)
  ) u_timing (
    .clk            (p_clock),
    .rst_n          (rst_n),
    .enable         (enable),
    .vsync_nx       (vsync_nx),
    .href_nx        (href_nx),
    .fetch_nx       (fetch_nx),
    .frame_start_nx (frame_start_nx),
    .pix_x          (pix_x)
  );

`ifdef DVP_TX_TEST_PATTERN_EN
  logic       pattern_q;
  logic [2:0] band;

  // Source selection is frozen for the whole frame at its first vsync cycle.
  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n)              pattern_q <= 1'b0;
    else if (frame_start_nx) pattern_q <= pattern_sel;
  end

  assign band        = 3'((int'(pix_x) * 8) / H_ACTIVE);
  assign bar_pixel   = bar_colour(band);
  assign use_pattern = pattern_q;
`else
  assign bar_pixel   = 16'h0000;
  assign use_pattern = 1'b0;
`endif

  // A starved fetch still sends a black pixel: DVP timing cannot stall.
  assign pix_src      = use_pattern ? bar_pixel : (s_valid ? s_pixel : 16'h0000);
  assign s_ready      = fetch_nx && !use_pattern;
  assign underrun_set = s_ready && !s_valid;

  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n) begin
      vsync       <= 1'b0;
      href        <= 1'b0;
      frame_start <= 1'b0;
      p_data      <= 8'h00;
      pix_q       <= 16'h0000;
      underrun    <= 1'b0;
    end else begin
      vsync       <= vsync_nx;
      href        <= href_nx;
      frame_start <= frame_start_nx;
      if (fetch_nx) pix_q <= pix_src;
      if (!href_nx)      p_data <= 8'h00;
      else if (fetch_nx) p_data <= pix_src[15:8];
      else               p_data <= pix_q[7:0];
      if (underrun_set)      underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
    end
  end

endmodule
